sdram_init_monitor: RTL and testbench
=====================================

Name: sdram_init_monitor

Overview:
- Device-side responder for the SDRAM init command bus (cmd/ba/addr/init_end), i.e. the receiving end of the init controller.
- Decodes the power-up sequence PRECHARGE-ALL, AUTO_REFRESH x N, LOAD_MODE_REGISTER and enforces minimum timing between these commands.
- Captures the programmed mode register and reports device-ready or a sticky error code.
- Used as a synthesizable in-line protocol checker and as the front end of the SDRAM behavioural responder.

Parameters:
T_POWER_UP, 350, min NOP/deselect cycles after reset release before the first PRECHARGE
T_RP, 2, min cycles from PRECHARGE to first AUTO_REFRESH
T_RFC, 7, min cycles from AUTO_REFRESH to the next AUTO_REFRESH or to LMR
T_MRD, 2, cycles from LMR to device-ready
AR_NUM, 2, required AUTO_REFRESH count before LMR
CNT_W, 16, timing counter width, saturating

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
cmd_i  input  4  {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRE 0010, AR 0001, LMR 0000; cs_n=1 is deselect and is treated as NOP
ba_i  input  2  bank address
addr_i  input  13  address bus
init_end_i  input  1  controller init-done flag
dev_ready_o  output  1  init sequence completed legally
mode_reg_o  output  13  captured LMR address word
cas_lat_o  output  3  mode_reg_o[6:4]
burst_len_o  output  3  mode_reg_o[2:0]
ar_cnt_o  output  4  AUTO_REFRESH commands accepted
err_o  output  1  sticky protocol error
err_code_o  output  4  first error code; 0 = none

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low on sys_rst_n. All state is registered.
- Reset values: dev_ready_o=0, mode_reg_o=0, ar_cnt_o=0, err_o=0, err_code_o=0. State is S_PWRUP and cnt=0.
- Counter: cnt clears to 0 on the edge that samples a non-NOP command. It increments on every other edge and saturates at all-ones.
- Command legality: a command sampled at edge E is legal only if cnt >= threshold at E.
- Output latency: outputs update on the same edge the command is sampled, so they are visible one cycle after the command is driven.
- Any other cmd value (ACT, RD, WR, BST) before S_READY gives code 7 (illegal).
- S_PWRUP:
  - PRE with cnt<T_POWER_UP: code 1 (early).
  - PRE with addr_i[10]=0: code 2 (not precharge-all).
  - PRE otherwise: go to S_TRP.
  - AR or LMR: code 3 (order).
- S_TRP:
  - AR with cnt>=T_RP: ar_cnt+1, go to S_REF.
  - AR with cnt<T_RP: code 4 (timing).
  - PRE or LMR: code 3.
- S_REF:
  - AR with cnt>=T_RFC: ar_cnt+1, saturating at 15.
  - LMR with ar_cnt>=AR_NUM and cnt>=T_RFC: capture addr_i into mode_reg_o, go to S_TMRD.
  - LMR with ar_cnt<AR_NUM: code 3.
  - Any command with cnt<T_RFC: code 4.
  - PRE: code 3.
- LMR field check: ba_i!=0, addr_i[12:10]!=0, or addr_i[6:4] not in {2,3} gives code 6 (bad mode). Timing and order checks take precedence over code 6.
- S_TMRD:
  - Non-NOP command: code 4.
  - Edge where cnt reaches T_MRD: dev_ready_o=1, go to S_READY.
- S_READY: terminal until reset. Commands are not checked; dev_ready_o holds 1.
- init_end_i=1 in any state before S_READY gives code 5 (end early). A command error in the same cycle wins.
- Errors: the first error sets err_o=1 and latches err_code_o, then the block goes to S_ERR. S_ERR is held until reset with dev_ready_o=0; later errors are ignored.
- Reset mid-sequence: all outputs return to reset values at once and the power-up count restarts.

Optional Feature:
- Macro INIT_MON_TIMEOUT_EN. When defined, adds parameter T_TIMEOUT, default 1000, and a saturating watchdog counter.
- The watchdog counts edges since reset release. If S_READY is not reached when it hits T_TIMEOUT, code 8 (timeout) is raised.
- When undefined, no watchdog logic exists and code 8 never occurs.

Test Plan:
- Legal sequence: 352 NOPs, PRE addr 13'h1fff ba 3, 4 NOPs, AR, 12 NOPs, AR, 12 NOPs, LMR addr 55 ba 0 -> after 2 more edges dev_ready_o=1, mode_reg_o=55, cas_lat_o=3, burst_len_o=7, ar_cnt_o=2, err_o=0.
- PRE after 100 NOPs -> err_o=1, err_code_o=1 one cycle later; later legal commands leave err_code_o=1.
- PRE addr 13'h0000 after 352 NOPs -> err_code_o=2. Separately, LMR after a single AR -> err_code_o=3.
- Second AR 3 cycles after the first -> err_code_o=4. Separately, LMR addr 13'h0017 (CAS=1) with legal timing -> err_code_o=6.
- init_end_i=1 during S_REF -> err_code_o=5. Separately, sys_rst_n low mid-S_REF -> all outputs 0 asynchronously, and the legal sequence then completes.
- With INIT_MON_TIMEOUT_EN and T_TIMEOUT=500, NOPs only -> err_code_o=8 at edge 500. Without the macro, same stimulus -> err_o stays 0.

Source files
------------

// File: rtl/sdram_init_monitor.sv
// Device-side monitor for the SDRAM power-up command sequence (PRE-ALL, AR xN, LMR).
// Optional watchdog on reaching device-ready is enabled by defining INIT_MON_TIMEOUT_EN.
module sdram_init_monitor #(
  parameter int unsigned T_POWER_UP = 350,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned T_MRD      = 2,
  parameter int unsigned AR_NUM     = 2,
  parameter int unsigned CNT_W      = 16
`ifdef INIT_MON_TIMEOUT_EN
  ,
  parameter int unsigned T_TIMEOUT  = 1000
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  cmd_i,
  input  logic [1:0]  ba_i,
  input  logic [12:0] addr_i,
  input  logic        init_end_i,
  output logic        dev_ready_o,
  output logic [12:0] mode_reg_o,
  output logic [2:0]  cas_lat_o,
  output logic [2:0]  burst_len_o,
  output logic [3:0]  ar_cnt_o,
  output logic        err_o,
  output logic [3:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_TRP   = 3'd1,
    S_REF   = 3'd2,
    S_TMRD  = 3'd3,
    S_READY = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Mode word must have zero bank/reserved bits and a CAS latency of 2 or 3.
  function automatic logic mode_ok(input logic [1:0] ba, input logic [12:0] addr);
    logic ok;
    ok = (ba == 2'd0) && (addr[12:10] == 3'd0) &&
         ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3));
    return ok;
  endfunction

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]     ar_cnt_q, ar_cnt_d;
  logic [12:0]    mode_reg_q, mode_reg_d;
  logic           dev_ready_q, dev_ready_d;
  logic           err_q, err_d;
  logic [3:0]     err_code_q, err_code_d;

  logic           is_nop_s, is_pre_s, is_ar_s, is_lmr_s, is_other_s;
  logic           cmd_err_s;
  logic [3:0]     cmd_code_s;
  logic           chk_active_s;
  logic           wd_hit_s;

  assign is_nop_s   = cmd_i[3] || (cmd_i == CMD_NOP);
  assign is_pre_s   = (cmd_i == CMD_PRE);
  assign is_ar_s    = (cmd_i == CMD_AR);
  assign is_lmr_s   = (cmd_i == CMD_LMR);
  assign is_other_s = !is_nop_s && !is_pre_s && !is_ar_s && !is_lmr_s;

  assign chk_active_s = (state_q != S_READY) && (state_q != S_ERR);

`ifdef INIT_MON_TIMEOUT_EN
  logic [CNT_W-1:0] wd_q, wd_d;

  // Watchdog edge counter since reset release, saturating.
  always_comb begin
    if (wd_q == {CNT_W{1'b1}}) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wd_hit_s = (wd_d >= CNT_W'(T_TIMEOUT));

  // Watchdog register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wd_q <= {CNT_W{1'b0}};
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_hit_s = 1'b0;
`endif

  // Next-state, timing counter and output computation.
  always_comb begin
    state_d     = state_q;
    ar_cnt_d    = ar_cnt_q;
    mode_reg_d  = mode_reg_q;
    dev_ready_d = dev_ready_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    cmd_err_s   = 1'b0;
    cmd_code_s  = 4'd0;

    if (!is_nop_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      S_PWRUP: begin
        if (is_other_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd7;
        end else if (is_pre_s) begin
          if (cnt_q < CNT_W'(T_POWER_UP)) begin
            cmd_err_s = 1'b1; cmd_code_s = 4'd1;
          end else if (!addr_i[10]) begin
            cmd_err_s = 1'b1; cmd_code_s = 4'd2;
          end else begin
            state_d = S_TRP;
          end
        end else if (is_ar_s || is_lmr_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd3;
        end else begin
          state_d = S_PWRUP;
        end
      end
      S_TRP: begin
        if (is_other_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd7;
        end else if (is_ar_s) begin
          if (cnt_q >= CNT_W'(T_RP)) begin
            ar_cnt_d = ar_cnt_q + 4'd1;
            state_d  = S_REF;
          end else begin
            cmd_err_s = 1'b1; cmd_code_s = 4'd4;
          end
        end else if (is_pre_s || is_lmr_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd3;
        end else begin
          state_d = S_TRP;
        end
      end
      S_REF: begin
        if (is_other_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd7;
        end else if (!is_nop_s && (cnt_q < CNT_W'(T_RFC))) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd4;
        end else if (is_pre_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd3;
        end else if (is_ar_s) begin
          if (ar_cnt_q == 4'd15) begin
            ar_cnt_d = ar_cnt_q;
          end else begin
            ar_cnt_d = ar_cnt_q + 4'd1;
          end
        end else if (is_lmr_s) begin
          // Order beats field content: an early LMR reports 3 even with a bad mode word.
          if (ar_cnt_q < 4'(AR_NUM)) begin
            cmd_err_s = 1'b1; cmd_code_s = 4'd3;
          end else if (!mode_ok(ba_i, addr_i)) begin
            cmd_err_s = 1'b1; cmd_code_s = 4'd6;
          end else begin
            mode_reg_d = addr_i;
            state_d    = S_TMRD;
          end
        end else begin
          state_d = S_REF;
        end
      end
      S_TMRD: begin
        if (is_other_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd7;
        end else if (!is_nop_s) begin
          cmd_err_s = 1'b1; cmd_code_s = 4'd4;
        end else if (cnt_d >= CNT_W'(T_MRD)) begin
          dev_ready_d = 1'b1;
          state_d     = S_READY;
        end else begin
          state_d = S_TMRD;
        end
      end
      S_READY: begin
        dev_ready_d = 1'b1;
      end
      S_ERR: begin
        dev_ready_d = 1'b0;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    // Command errors outrank the early init_end flag, which outranks the watchdog.
    if (cmd_err_s) begin
      err_d = 1'b1; err_code_d = cmd_code_s; state_d = S_ERR; dev_ready_d = 1'b0;
    end else if (chk_active_s && init_end_i) begin
      err_d = 1'b1; err_code_d = 4'd5; state_d = S_ERR; dev_ready_d = 1'b0;
    end else if (chk_active_s && wd_hit_s) begin
      err_d = 1'b1; err_code_d = 4'd8; state_d = S_ERR; dev_ready_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= {CNT_W{1'b0}};
      ar_cnt_q    <= 4'd0;
      mode_reg_q  <= 13'd0;
      dev_ready_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ar_cnt_q    <= ar_cnt_d;
      mode_reg_q  <= mode_reg_d;
      dev_ready_q <= dev_ready_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign dev_ready_o = dev_ready_q;
  assign mode_reg_o  = mode_reg_q;
  assign cas_lat_o   = mode_reg_q[6:4];
  assign burst_len_o = mode_reg_q[2:0];
  assign ar_cnt_o    = ar_cnt_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor; inputs change 1ns after each rising edge.
module tb_sdram_init_monitor;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] DES = 4'b1000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  cmd_i = NOP;
  logic [1:0]  ba_i = 2'd0;
  logic [12:0] addr_i = 13'd0;
  logic        init_end_i = 1'b0;
  logic        dev_ready_o;
  logic [12:0] mode_reg_o;
  logic [2:0]  cas_lat_o;
  logic [2:0]  burst_len_o;
  logic [3:0]  ar_cnt_o;
  logic        err_o;
  logic [3:0]  err_code_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

`ifdef INIT_MON_TIMEOUT_EN
  sdram_init_monitor #(.T_TIMEOUT(500)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_i(cmd_i), .ba_i(ba_i),
    .addr_i(addr_i), .init_end_i(init_end_i), .dev_ready_o(dev_ready_o),
    .mode_reg_o(mode_reg_o), .cas_lat_o(cas_lat_o), .burst_len_o(burst_len_o),
    .ar_cnt_o(ar_cnt_o), .err_o(err_o), .err_code_o(err_code_o)
  );
`else
  sdram_init_monitor dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_i(cmd_i), .ba_i(ba_i),
    .addr_i(addr_i), .init_end_i(init_end_i), .dev_ready_o(dev_ready_o),
    .mode_reg_o(mode_reg_o), .cas_lat_o(cas_lat_o), .burst_len_o(burst_len_o),
    .ar_cnt_o(ar_cnt_o), .err_o(err_o), .err_code_o(err_code_o)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic ie);
    cmd_i = c; ba_i = b; addr_i = a; init_end_i = ie;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, 2'd0, 13'd0, 1'b0);
  endtask

  task automatic do_reset();
    cmd_i = NOP; ba_i = 2'd0; addr_i = 13'd0; init_end_i = 1'b0;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic to_first_ar();
    nops(352);
    cyc(PRE, 2'd3, 13'h1fff, 1'b0);
    nops(4);
    cyc(AR, 2'd0, 13'd0, 1'b0);
  endtask

  task automatic to_lmr_ready(input logic [12:0] mode);
    to_first_ar();
    nops(12);
    cyc(AR, 2'd0, 13'd0, 1'b0);
    nops(12);
    cyc(LMR, 2'd0, mode, 1'b0);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_ready", {31'd0, dev_ready_o}, 32'd0);
    check("rst_mode", {19'd0, mode_reg_o}, 32'd0);
    check("rst_arcnt", {28'd0, ar_cnt_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_code", {28'd0, err_code_o}, 32'd0);

    // Legal sequence
    to_lmr_ready(13'd55);
    check("legal_lmr_ready0", {31'd0, dev_ready_o}, 32'd0);
    nops(1);
    check("legal_tmrd1_ready0", {31'd0, dev_ready_o}, 32'd0);
    nops(1);
    check("legal_ready", {31'd0, dev_ready_o}, 32'd1);
    check("legal_mode", {19'd0, mode_reg_o}, 32'd55);
    check("legal_cas", {29'd0, cas_lat_o}, 32'd3);
    check("legal_bl", {29'd0, burst_len_o}, 32'd7);
    check("legal_arcnt", {28'd0, ar_cnt_o}, 32'd2);
    check("legal_err", {31'd0, err_o}, 32'd0);
    cyc(ACT, 2'd0, 13'd0, 1'b1);
    nops(3);
    check("ready_hold", {31'd0, dev_ready_o}, 32'd1);
    check("ready_nocheck", {31'd0, err_o}, 32'd0);

    // Early PRE after 100 NOPs, sticky
    do_reset();
    nops(100);
    cyc(PRE, 2'd0, 13'h1fff, 1'b0);
    check("early_err", {31'd0, err_o}, 32'd1);
    check("early_code", {28'd0, err_code_o}, 32'd1);
    nops(400);
    cyc(PRE, 2'd0, 13'h1fff, 1'b0);
    nops(4);
    cyc(AR, 2'd0, 13'd0, 1'b0);
    check("sticky_code", {28'd0, err_code_o}, 32'd1);
    check("sticky_arcnt", {28'd0, ar_cnt_o}, 32'd0);
    check("sticky_ready", {31'd0, dev_ready_o}, 32'd0);

    // Boundary: PRE after 349 NOPs is early
    do_reset();
    nops(349);
    cyc(PRE, 2'd0, 13'h1fff, 1'b0);
    check("pre349_code", {28'd0, err_code_o}, 32'd1);

    // Boundary: PRE at exactly 350, AR at exactly T_RP, then AR at cnt=6 is early
    do_reset();
    nops(350);
    cyc(PRE, 2'd0, 13'h0400, 1'b0);
    nops(2);
    cyc(AR, 2'd0, 13'd0, 1'b0);
    check("bound_ar1_cnt", {28'd0, ar_cnt_o}, 32'd1);
    check("bound_ar1_err", {31'd0, err_o}, 32'd0);
    nops(6);
    cyc(AR, 2'd0, 13'd0, 1'b0);
    check("rfc6_code", {28'd0, err_code_o}, 32'd4);

    // PRE without A10
    do_reset();
    nops(352);
    cyc(PRE, 2'd0, 13'h0000, 1'b0);
    check("pre_a10_code", {28'd0, err_code_o}, 32'd2);

    // LMR after one AR
    do_reset();
    to_first_ar();
    nops(12);
    cyc(LMR, 2'd0, 13'd55, 1'b0);
    check("lmr_order_code", {28'd0, err_code_o}, 32'd3);

    // Second AR 3 cycles after the first
    do_reset();
    to_first_ar();
    nops(2);
    cyc(AR, 2'd0, 13'd0, 1'b0);
    check("ar_timing_code", {28'd0, err_code_o}, 32'd4);

    // Bad CAS latency in mode word
    do_reset();
    to_lmr_ready(13'h0017);
    check("bad_mode_code", {28'd0, err_code_o}, 32'd6);
    check("bad_mode_nocap", {19'd0, mode_reg_o}, 32'd0);

    // init_end during S_REF
    do_reset();
    to_first_ar();
    nops(3);
    cyc(NOP, 2'd0, 13'd0, 1'b1);
    check("init_end_code", {28'd0, err_code_o}, 32'd5);

    // Deselect counts as NOP; ACT is illegal
    do_reset();
    for (int i = 0; i < 352; i++) cyc(DES, 2'd0, 13'd0, 1'b0);
    cyc(PRE, 2'd0, 13'h1fff, 1'b0);
    nops(2);
    cyc(AR, 2'd0, 13'd0, 1'b0);
    check("des_arcnt", {28'd0, ar_cnt_o}, 32'd1);
    check("des_err", {31'd0, err_o}, 32'd0);
    cyc(ACT, 2'd0, 13'd0, 1'b0);
    check("act_code", {28'd0, err_code_o}, 32'd7);

    // Asynchronous reset mid S_REF, then legal sequence completes
    do_reset();
    to_first_ar();
    nops(3);
    check("pre_async_arcnt", {28'd0, ar_cnt_o}, 32'd1);
    sys_rst_n = 1'b0;
    #2;
    check("async_arcnt", {28'd0, ar_cnt_o}, 32'd0);
    check("async_ready", {31'd0, dev_ready_o}, 32'd0);
    check("async_err", {31'd0, err_o}, 32'd0);
    do_reset();
    to_lmr_ready(13'd55);
    nops(2);
    check("after_rst_ready", {31'd0, dev_ready_o}, 32'd1);
    check("after_rst_mode", {19'd0, mode_reg_o}, 32'd55);

    // Watchdog behaviour with NOPs only
    do_reset();
`ifdef INIT_MON_TIMEOUT_EN
    nops(499);
    check("wd499_err", {31'd0, err_o}, 32'd0);
    nops(1);
    check("wd500_err", {31'd0, err_o}, 32'd1);
    check("wd500_code", {28'd0, err_code_o}, 32'd8);
`else
    nops(600);
    check("nowd_err", {31'd0, err_o}, 32'd0);
    check("nowd_code", {28'd0, err_code_o}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
